// File: rtl/piso_tx_scheduler.sv
// piso_tx_scheduler: round-robin arbiter that feeds one PISO converter and paces frames by baud and parity length
module piso_tx_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_CTRL_WIDTH = 2,
  parameter int NUM_REQ = 4
) (
  input  logic                               DCLK,
  input  logic                               RST_N,
  input  logic                               SCHED_EN,
  input  logic [NUM_REQ-1:0]                 REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      REQ_DI,
  input  logic [NUM_REQ-1:0]                 REQ_PARITY_EN,
  input  logic [NUM_REQ*BAUD_CTRL_WIDTH-1:0] REQ_BAUD,
  output logic [NUM_REQ-1:0]                 ACK,
  output logic                               DVALID,
  output logic [DATA_WIDTH-1:0]              DI,
  output logic                               CTRL_PARITY_EN,
  output logic [BAUD_CTRL_WIDTH-1:0]         CTRL_BAUD_RATE,
  output logic                               BUSY,
  output logic [$clog2(NUM_REQ)-1:0]         GNT_ID
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2((DATA_WIDTH + 3) * 16);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, GAP} state_t;
  state_t state;
  logic [IW-1:0] ptr, win, idx;
  logic found;
  logic [CW-1:0] cnt, fc_m1;
  always_comb begin
    win = ptr;
    idx = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + IW'(k);
      if (!found && REQ[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  // DI/CTRL_* are the holding registers, so the frame length comes from the captured word
  assign fc_m1 = CW'((DATA_WIDTH + 2 + int'(CTRL_PARITY_EN)) * (16 >> CTRL_BAUD_RATE) - 1);
  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      ptr <= '0;
      GNT_ID <= '0;
      cnt <= '0;
      DI <= '0;
      CTRL_PARITY_EN <= 1'b0;
      CTRL_BAUD_RATE <= '0;
      DVALID <= 1'b0;
      ACK <= '0;
      BUSY <= 1'b0;
    end else begin
      case (state)
        IDLE: if (SCHED_EN && found) begin
          DI <= REQ_DI[win*DATA_WIDTH +: DATA_WIDTH];
          CTRL_PARITY_EN <= REQ_PARITY_EN[win];
          CTRL_BAUD_RATE <= REQ_BAUD[win*BAUD_CTRL_WIDTH +: BAUD_CTRL_WIDTH];
          GNT_ID <= win;
          ACK <= NUM_REQ'(1) << win;
          DVALID <= 1'b1;
          BUSY <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          DVALID <= 1'b0;
          ACK <= '0;
          cnt <= fc_m1;
          ptr <= GNT_ID + IW'(1);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= GAP;
        end
        GAP: begin
          BUSY <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/piso_tx_scheduler.md
PISO_TX_SCHEDULER -- requirements
Module: piso_tx_scheduler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 8, parallel word width
- BAUD_CTRL_WIDTH, 2, baud-select width
- NUM_REQ, 4, requester count (power of 2)
REQ-002 Ports (name, direction, width, meaning), one per line:
- DCLK, in, 1, the single clock
- RST_N, in, 1, reset; asynchronous, active-low
- SCHED_EN, in, 1, permits new grants
- REQ, in, NUM_REQ, per-requester transmit request
- REQ_DI, in, NUM_REQ*DATA_WIDTH, per-requester word; slice i is requester i
- REQ_PARITY_EN, in, NUM_REQ, per-requester parity enable
- REQ_BAUD, in, NUM_REQ*BAUD_CTRL_WIDTH, per-requester baud select
- ACK, out, NUM_REQ, one-cycle acceptance pulse to the requester
- DVALID, out, 1, load strobe to the converter
- DI, out, DATA_WIDTH, word to the converter
- CTRL_PARITY_EN, out, 1, parity enable to the converter
- CTRL_BAUD_RATE, out, BAUD_CTRL_WIDTH, baud select to the converter
- BUSY, out, 1, a frame is in flight
- GNT_ID, out, log2(NUM_REQ), index of the current or last granted requester

Function
REQ-003 The FSM SHALL have four states: IDLE, LOAD, WAIT, GAP.
REQ-004 IDLE with SCHED_EN=1 and REQ!=0:
- Pick a winner by round-robin, searching upward from ptr with wrap-around.
- Capture the winner's REQ_DI, REQ_PARITY_EN and REQ_BAUD into holding registers.
- Set GNT_ID to the winner.
- Go to LOAD.
REQ-005 IDLE with SCHED_EN=0 or REQ=0: stay in IDLE; no ACK.
REQ-006 LOAD lasts exactly 1 cycle:
- DVALID=1.
- ACK[GNT_ID]=1.
- Load the frame counter with FC-1.
- Set ptr to GNT_ID+1 (mod NUM_REQ).
- Go to WAIT.
REQ-007 Frame length:
- FC = (DATA_WIDTH+2+CTRL_PARITY_EN) * CPB.
- CPB = 16/8/4/2 for baud select 0/1/2/3.
- Counter width SHALL hold FC-1 at the maximum (175 at the defaults).
REQ-008 WAIT SHALL decrement the counter each cycle and go to GAP when the counter is 1, so that LOAD+WAIT span exactly FC cycles.
REQ-009 GAP lasts exactly 1 cycle, then the FSM returns to IDLE.
REQ-010 DI, CTRL_PARITY_EN and CTRL_BAUD_RATE SHALL be driven from the holding registers and stay stable from LOAD through the end of GAP.
REQ-011 Spacing:
- BUSY=1 in LOAD, WAIT and GAP: FC+1 cycles per frame.
- Minimum spacing between consecutive DVALID pulses is FC+2 cycles.
REQ-012 Outputs outside LOAD: DVALID=0 and ACK=0.
REQ-013 ACK SHALL never assert for more than one requester in the same cycle.
REQ-014 Requester handshake:
- A requester holds REQ and its data until ACK.
- Changes after the capture cycle SHALL NOT affect the frame in flight.
- If REQ drops after capture, the frame still completes and ACK still pulses.
REQ-015 Dropping SCHED_EN mid-frame SHALL NOT abort the frame; it only blocks the next grant in IDLE.
REQ-016 REQ asserted during LOAD, WAIT or GAP SHALL be considered only at the next IDLE cycle.
REQ-017 A requester with REQ held continuously SHALL be granted at least once every NUM_REQ grants.

Reset
REQ-018 RST_N=0 SHALL immediately, independent of DCLK, force:
- state=IDLE, ptr=0, GNT_ID=0, counter=0
- holding registers=0
- DVALID=0, ACK=0, DI=0, CTRL_PARITY_EN=0, CTRL_BAUD_RATE=0, BUSY=0
REQ-019 Reset during WAIT SHALL abandon the frame and issue no further ACK.
REQ-020 After RST_N deasserts, the first arbitration SHALL occur on the first DCLK edge with the FSM in IDLE.

Verification
REQ-021 Single request:
- Stimulus: REQ=0100, REQ_DI[2]=0xA5, parity=0, baud=3 (FC=20).
- Response: DVALID pulses one cycle after the request is seen, with DI=0xA5; ACK=0100 in the same cycle; BUSY high for 21 cycles.
REQ-022 All request, held:
- Stimulus: REQ=1111 held, all baud=3, parity=0.
- Response: grant order 0,1,2,3,0; DVALID spacing exactly 22 cycles.
REQ-023 Parity and slowest baud:
- Stimulus: parity=1, baud=0.
- Response: FC=176; BUSY high 177 cycles; CTRL_BAUD_RATE=0 and CTRL_PARITY_EN=1 stable throughout.
REQ-024 SCHED_EN gating:
- Stimulus: SCHED_EN=0 with REQ=0001.
- Response: no DVALID. Once SCHED_EN=1: DVALID and ACK[0] one cycle later.
- Stimulus: SCHED_EN dropped during WAIT.
- Response: the frame completes, BUSY falls on schedule, no new grant follows.
REQ-025 Mid-frame changes and reset:
- Stimulus: REQ_DI changed during WAIT.
- Response: DI unchanged.
- Stimulus: RST_N=0 mid-WAIT.
- Response: all outputs 0 asynchronously. After release with REQ=1000: requester 3 granted, and ptr resets so that with REQ=1111 requester 0 is granted first.
